// File: rtl/video_timing_pkg.sv
// Shared raster-timing types and constants for video_timing_gen and its axis FSMs.
package video_timing_pkg;

    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FP_1080P     = 88;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_BP_1080P     = 148;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;
    localparam int POS_MAX        = 4095;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    typedef logic [2:0] dvh_sync_t;   // {D_sync, Vsync, Hsync}
    typedef logic [1:0] vh_blank_t;   // {Vblank, Hblank}

    // Left-to-right colour bars: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_COLOURS [8] = '{
        24'hFF_FF_FF, 24'hFF_FF_00, 24'h00_FF_FF, 24'h00_FF_00,
        24'hFF_00_FF, 24'hFF_00_00, 24'h00_00_FF, 24'h00_00_00
    };

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle presented by video_timing_gen to downstream video stages.
interface video_timing_gen_if;
    import video_timing_pkg::*;

    logic [23:0] vid_rgb_o;
    vh_blank_t   vh_blank_o;
    dvh_sync_t   dvh_sync_o;
    logic [11:0] h_pos_o;
    logic [11:0] v_pos_o;
    logic        sof_o;

    modport master (
        output vid_rgb_o, vh_blank_o, dvh_sync_o, h_pos_o, v_pos_o, sof_o
    );

    modport slave (
        input vid_rgb_o, vh_blank_o, dvh_sync_o, h_pos_o, v_pos_o, sof_o
    );
endinterface

// File: rtl/video_axis_fsm.sv
// One raster axis: phase FSM with down-counting phase timer plus a wrapping position counter.
//   state  | meaning
//   ACTIVE | visible region
//   FRONT  | front porch, blanked
//   SYNC   | sync pulse asserted, blanked
//   BACK   | back porch, blanked
module video_axis_fsm
    import video_timing_pkg::*;
#(
    parameter int ACT_LEN  = 1920,
    parameter int FP_LEN   = 88,
    parameter int SYNC_LEN = 44,
    parameter int BP_LEN   = 148,
    parameter bit POL      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        adv,
    output logic [11:0] pos,
    output logic        blank,
    output logic        sync,
    output logic        wrap
);

    localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

    phase_t      phase;
    logic [11:0] cnt;

    // Phase and position advance on separate enables: the vertical axis changes
    // phase at the start of horizontal blanking but counts lines at the line wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= ACTIVE;
            cnt   <= 12'(ACT_LEN - 1);
            pos   <= '0;
        end else begin
            if (step) begin
                if (cnt == 12'd0) begin
                    unique case (phase)
                        ACTIVE: begin phase <= FRONT;  cnt <= 12'(FP_LEN - 1);   end
                        FRONT:  begin phase <= SYNC;   cnt <= 12'(SYNC_LEN - 1); end
                        SYNC:   begin phase <= BACK;   cnt <= 12'(BP_LEN - 1);   end
                        BACK:   begin phase <= ACTIVE; cnt <= 12'(ACT_LEN - 1);  end
                    endcase
                end else begin
                    cnt <= cnt - 12'd1;
                end
            end
            if (adv) begin
                pos <= wrap ? 12'd0 : pos + 12'd1;
            end
        end
    end

    assign wrap  = adv && (pos == 12'(TOTAL - 1));
    assign blank = (phase != ACTIVE);
    assign sync  = (phase == SYNC) ? POL : !POL;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: blanking, syncs, coordinates, start-of-frame and a pixel stream.
// Define VIDEO_TIMING_GEN_PATTERN_EN for 8 colour bars; otherwise active video is BG_COLOUR.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int          H_ACTIVE  = H_ACTIVE_1080P,
    parameter int          H_FP      = H_FP_1080P,
    parameter int          H_SYNC    = H_SYNC_1080P,
    parameter int          H_BP      = H_BP_1080P,
    parameter int          V_ACTIVE  = V_ACTIVE_1080P,
    parameter int          V_FP      = V_FP_1080P,
    parameter int          V_SYNC    = V_SYNC_1080P,
    parameter int          V_BP      = V_BP_1080P,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter logic [23:0] BG_COLOUR = 24'h00_00_FF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cen_i,
    video_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_bad_total
        $error("video_timing_gen: line or frame total exceeds 12-bit position range");
    end

    logic [11:0] h_pos, v_pos;
    logic        h_blank, h_sync, h_wrap;
    logic        v_blank, v_sync, v_wrap_unused;
    logic        h_enter_front;
    logic        active;
    logic [23:0] colour;

    assign h_enter_front = cen_i && (h_pos == 12'(H_ACTIVE - 1));

    video_axis_fsm #(
        .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .POL(HS_POL)
    ) u_h_axis (
        .clk(clk_i), .rst(rst_i), .step(cen_i), .adv(cen_i),
        .pos(h_pos), .blank(h_blank), .sync(h_sync), .wrap(h_wrap)
    );

    video_axis_fsm #(
        .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .POL(VS_POL)
    ) u_v_axis (
        .clk(clk_i), .rst(rst_i), .step(h_enter_front), .adv(h_wrap),
        .pos(v_pos), .blank(v_blank), .sync(v_sync), .wrap(v_wrap_unused)
    );

    assign active = !h_blank && !v_blank;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    if (BAR_W < 1) begin : g_bad_bar
        $error("video_timing_gen: H_ACTIVE too small for 8 colour bars");
    end

    logic [11:0] bar;
    assign bar    = h_pos / 12'(BAR_W);
    assign colour = BAR_COLOURS[(bar > 12'd7) ? 3'd7 : bar[2:0]];
`else
    assign colour = BG_COLOUR;
`endif

    // Outputs present the pixel the counters point at; counters move on to the next one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid.vid_rgb_o  <= '0;
            vid.vh_blank_o <= 2'b11;
            vid.dvh_sync_o <= {1'b0, !VS_POL, !HS_POL};
            vid.h_pos_o    <= '0;
            vid.v_pos_o    <= '0;
            vid.sof_o      <= 1'b0;
        end else if (cen_i) begin
            vid.vid_rgb_o  <= active ? colour : 24'h0;
            vid.vh_blank_o <= {v_blank, h_blank};
            vid.dvh_sync_o <= {active, v_sync, h_sync};
            vid.h_pos_o    <= h_pos;
            vid.v_pos_o    <= v_pos;
            vid.sof_o      <= (h_pos == 12'd0) && (v_pos == 12'd0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster, checked against an arithmetic pixel model.
module tb_video_timing_gen;

    localparam int HA = 32, HFP = 4, HSY = 3, HBP = 5;
    localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 3;
    localparam bit HSP = 1'b1, VSP = 1'b0;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [23:0] rgb;
        logic [1:0]  blank;
        logic [2:0]  sync;
        logic [11:0] h;
        logic [11:0] v;
        logic        sof;
    } px_t;

    localparam px_t RESET_PX = '{rgb: 24'h0, blank: 2'b11, sync: {1'b0, !VSP, !HSP},
                                 h: 12'd0, v: 12'd0, sof: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    video_timing_gen_if vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .BG_COLOUR(24'h00_00_FF)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .vid(vif)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  n = 0;
    px_t q[$];
    px_t last_px = RESET_PX;
    int  cen_cnt = 0;
    bit  have_sof = 1'b0;

    function automatic logic [23:0] bar_colour(int h);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
        int b = h / (HA / 8);
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return 24'h0000FF;
`endif
    endfunction

    // Pixel k after reset, from the raster rules; vertical state switches at h = HA.
    function automatic px_t model_px(int k);
        px_t p;
        int h = k % HT;
        int v = (k / HT) % VT;
        int w = (h >= HA) ? v + 1 : v;
        bit hb = (h >= HA);
        bit vb = (w >= VA) && (w <= VT - 1);
        bit hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
        bit vs = (w >= VA + VFP) && (w < VA + VFP + VSY);
        bit de = !hb && !vb;
        p.rgb   = de ? bar_colour(h) : 24'h0;
        p.blank = {vb, hb};
        p.sync  = {de, vs ? VSP : !VSP, hs ? HSP : !HSP};
        p.h     = 12'(h);
        p.v     = 12'(v);
        p.sof   = (h == 0) && (v == 0);
        return p;
    endfunction

    function automatic px_t dut_px();
        px_t p;
        p.rgb   = vif.vid_rgb_o;
        p.blank = vif.vh_blank_o;
        p.sync  = vif.dvh_sync_o;
        p.h     = vif.h_pos_o;
        p.v     = vif.v_pos_o;
        p.sof   = vif.sof_o;
        return p;
    endfunction

    task automatic check_px(string name, px_t a, px_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: got rgb=%h blank=%b sync=%b h=%0d v=%0d sof=%b, want rgb=%h blank=%b sync=%b h=%0d v=%0d sof=%b",
                     name, $time, a.rgb, a.blank, a.sync, a.h, a.v, a.sof,
                     e.rgb, e.blank, e.sync, e.h, e.v, e.sof);
        end
    endtask

    task automatic check_int(string name, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, a, e);
        end
    endtask

    // Reference model: one expected pixel per enabled clock edge.
    always @(posedge clk) begin
        if (!rst && cen) begin
            q.push_back(model_px(n));
            n++;
        end
    end

    // Monitor: compares presented pixels on enabled edges, hold behaviour otherwise.
    always @(posedge clk) begin
        logic ce, r;
        px_t  a, e;
        ce = cen;
        r  = rst;
        #1;
        if (!r) begin
            a = dut_px();
            if (ce) begin
                if (q.size() == 0) begin
                    check_int("queue_underflow", 0, 1);
                end else begin
                    e = q.pop_front();
                    check_px("pixel", a, e);
                    last_px = e;
                end
                cen_cnt++;
                if (a.sof) begin
                    if (have_sof) check_int("sof_period", cen_cnt, FRAME);
                    have_sof = 1'b1;
                    cen_cnt  = 0;
                end
            end else begin
                check_px("hold", a, last_px);
            end
        end
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        #1 check_px("reset_init", dut_px(), RESET_PX);
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b1;

        // Continuous enable through two frames, then reset mid-frame at h=10, v=3.
        guard = 0;
        while (!(n > 2 * FRAME && n % HT == 10 && (n / HT) % VT == 3) && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        check_int("reset_point_reached", guard < 4 * FRAME ? 1 : 0, 1);
        #2;
        rst      = 1'b1;
        q.delete();
        n        = 0;
        last_px  = RESET_PX;
        have_sof = 1'b0;
        cen_cnt  = 0;
        #1 check_px("reset_mid", dut_px(), RESET_PX);
        @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Enable every other clock.
        for (int i = 0; i < 4 * FRAME; i++) begin
            cen = (i % 2 == 0);
            @(negedge clk);
        end

        // Random enable pattern.
        for (int i = 0; i < 5 * FRAME; i++) begin
            cen = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        cen = 1'b0;
        repeat (2) @(negedge clk);
        check_int("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Upstream source stage feeding video_uut.
- Generates the raster timing video_uut consumes:
  - vh_blank {Vblank, Hblank}
  - dvh_sync {D_sync, Vsync, Hsync}
  - a 24-bit pixel stream
- Driven by the video clock enable; default timing is CEA 1080p60 (2200x1125 total, 1920x1080 active).
- Exports raster coordinates and a start-of-frame pulse for other overlay stages.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (pixels)
- H_SYNC, 44, hsync width (pixels)
- H_BP, 148, horizontal back porch (pixels)
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- BG_COLOUR, 24'h00_00_FF, solid fill when the pattern feature is compiled out

Ports:
- clk_i  input  1  video clock
- rst_i  input  1  asynchronous active-high reset
- cen_i  input  1  video clock enable; all state advances only when high
- vid_rgb_o  output  24  R[23:16] G[15:8] B[7:0]; zero during blanking
- vh_blank_o  output  2  {Vblank, Hblank}
- dvh_sync_o  output  3  {D_sync, Vsync, Hsync}; D_sync = active video (~Vblank & ~Hblank)
- h_pos_o  output  12  horizontal position of the pixel currently presented
- v_pos_o  output  12  vertical position of the pixel currently presented
- sof_o  output  1  high for the one cen cycle presenting pixel (0,0)

Behaviour:
- Reset: clock is clk_i; reset is asynchronous, active-high, on rst_i. Reset values:
  - internal h/v counters = 0
  - vid_rgb_o = 0, vh_blank_o = 2'b11
  - dvh_sync_o = {1'b0, ~VS_POL, ~HS_POL}
  - h_pos_o = v_pos_o = 0, sof_o = 0
- After reset release, the first cen cycle registers pixel (0,0) onto the outputs (sof_o = 1).
- All outputs are registered, mutually aligned, and change only on clk_i edges with cen_i = 1; outputs hold while cen_i = 0.
- Per-axis FSM, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - A phase counter reloads with the next phase length minus 1 on each transition.
  - H FSM advances every cen cycle.
  - V FSM advances once per line, on the cen cycle where the H FSM enters FRONT (h = H_ACTIVE).
- Line total = H_ACTIVE+H_FP+H_SYNC+H_BP (2200). Frame total = V_ACTIVE+V_FP+V_SYNC+V_BP (1125).
- Hblank = 1 for h in [H_ACTIVE, H_TOTAL-1].
- Hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- Vblank and Vsync change only at h = H_ACTIVE, so Vblank rises in the same cycle as Hblank on line V_ACTIVE-1.
  - Vblank stays high until h = H_ACTIVE of line V_TOTAL-1. Line 0 is fully unblanked.
  - Vsync is active for V_SYNC lines, starting at h = H_ACTIVE of line V_ACTIVE+V_FP-1.
- Wrap: h = H_TOTAL-1 -> 0, and v increments. At v = V_TOTAL-1, v wraps to 0 on that same cycle.
- Positions are 12-bit unsigned; all parameters must satisfy totals <= 4095. Elaboration-time assertion fails otherwise.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). No partial line or frame is completed.

Optional Feature:
- Macro: VIDEO_TIMING_GEN_PATTERN_EN.
- Defined: active video carries 8 vertical colour bars, each H_ACTIVE/8 wide, left to right:
  - FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000
  - Bar index = h / (H_ACTIVE/8), saturated at 7.
- Undefined: active video = BG_COLOUR; no divider or bar logic is synthesized.

Decomposition:
- Package video_timing_pkg holds:
  - 1080p60 constants
  - a typedef for the phase enum {ACTIVE, FRONT, SYNC, BACK}
  - typedefs for the 3-bit sync bundle and 2-bit blank bundle
  - the colour-bar constant array
- One sub-module, video_axis_fsm:
  - parameterized by the four phase lengths and the sync polarity
  - inputs: step enable
  - outputs: position, blank, sync, wrap
  - instantiated twice (H and V).

Test Plan:
- Reset, release, cen_i = 1 constant:
  - pixel (0,0) appears with vh_blank_o = 00, D_sync = 1, sof_o = 1.
  - Hblank rises exactly 1920 cen cycles later.
  - Hsync is high for cycles 2008..2051 of the line.
- Line/frame periods:
  - Hblank rising edges are exactly 2200 cen cycles apart.
  - sof_o pulses are exactly 2,475,000 cen cycles apart.
  - Vsync lasts 5 lines × 2200 = 11000 cycles.
- Vertical edge alignment:
  - Vblank rises in the same cycle as Hblank rise at v_pos_o = 1079, h_pos_o = 1920.
  - Vblank falls at v_pos_o = 1124, h_pos_o = 1920.
- cen_i toggling 1-of-2:
  - all outputs hold in cen-low cycles.
  - line period becomes 4400 clk cycles; values are identical to the cen=1 run.
- rst_i pulse at h = 1000, v = 500:
  - outputs reach reset values before the next clk edge.
  - after release, the sequence restarts at (0,0) with sof_o = 1.
- Pattern, macro defined:
  - h = 0 -> FFFFFF; h = 240 -> FFFF00; h = 1919 -> 000000.
  - during blanking -> 000000.
- Pattern, macro undefined: active video = 0000FF throughout.
